// File: rtl/usb_pkg.sv
// Shared encodings for the bulk OUT endpoint: handshake PID types and
// controller state encoding.
package usb_pkg;

    localparam logic [1:0] HSK_ACK   = 2'b00;
    localparam logic [1:0] HSK_NAK   = 2'b01;
    localparam logic [1:0] HSK_NYET  = 2'b10;
    localparam logic [1:0] HSK_STALL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RX_ACCEPT,
        RX_DISCARD,
        HSK
    } state_t;

endpackage

// File: rtl/bulk_out_flow_ctrl.sv
// Bulk OUT endpoint transaction controller: token handshake decision, DATA
// toggle tracking and gating of the byte stream into the OUT FIFO.
// Optional: define BULK_OUT_NYET_EN to answer NYET on accepts when space is low.
module bulk_out_flow_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned MAX_PKT    = 512,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned LEVEL_BITS = 12
) (
    input  logic                  bulk_ep_out_clock,
    input  logic                  reset_n,
    input  logic                  tok_out_i,
    input  logic                  tok_ping_i,
    input  logic                  pid_toggle_i,
    input  logic                  pkt_abort_i,
    input  logic                  halt_i,
    input  logic                  clear_halt_i,
    input  logic [LEVEL_BITS-1:0] level_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    input  logic                  s_tlast_i,
    input  logic [7:0]            s_tdata_i,
    input  logic                  crc_err_i,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic [7:0]            m_tdata_o,
    output logic                  m_tuser_o,
    output logic                  hsk_valid_o,
    output logic [1:0]            hsk_type_o,
    input  logic                  hsk_ready_i,
    output logic                  toggle_o,
    output logic                  overflow_o
);

    localparam logic [LEVEL_BITS:0] DEPTH_W = (LEVEL_BITS+1)'(FIFO_DEPTH);
    localparam logic [LEVEL_BITS:0] MAX_W   = (LEVEL_BITS+1)'(MAX_PKT);

    state_t          state_q, state_d;
    logic            toggle_q, toggle_d;
    logic            dup_q, dup_d;
    logic            first_q, first_d;
    logic            fwd_q, fwd_d;
    logic            abort_q, abort_d;
    logic            overflow_q, overflow_d;
    logic [1:0]      pend_q, pend_d;
    logic [1:0]      hsk_type_q, hsk_type_d;
    logic [LEVEL_BITS:0] free;
    logic            dup_now;
    logic [1:0]      accept_type;

    assign free = DEPTH_W - {1'b0, level_i};

    // Duplicate status must be known on the first beat itself (a ZLP is first and last).
    assign dup_now = first_q ? (pid_toggle_i != toggle_q) : dup_q;

`ifdef BULK_OUT_NYET_EN
    localparam logic [LEVEL_BITS:0] MAX2_W = (LEVEL_BITS+1)'(2 * MAX_PKT);
    logic nyet_q, nyet_d;

    assign accept_type = nyet_q ? HSK_NYET : HSK_ACK;

    always_ff @(posedge bulk_ep_out_clock) begin
        if (!reset_n) nyet_q <= 1'b0;
        else          nyet_q <= nyet_d;
    end

    always_comb begin
        nyet_d = nyet_q;
        if (state_q == IDLE && tok_out_i) nyet_d = (free < MAX2_W);
    end
`else
    assign accept_type = HSK_ACK;
`endif

    always_ff @(posedge bulk_ep_out_clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            toggle_q   <= 1'b0;
            dup_q      <= 1'b0;
            first_q    <= 1'b0;
            fwd_q      <= 1'b0;
            abort_q    <= 1'b0;
            overflow_q <= 1'b0;
            pend_q     <= '0;
            hsk_type_q <= '0;
        end else begin
            state_q    <= state_d;
            toggle_q   <= toggle_d;
            dup_q      <= dup_d;
            first_q    <= first_d;
            fwd_q      <= fwd_d;
            abort_q    <= abort_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            hsk_type_q <= hsk_type_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        toggle_d    = toggle_q;
        dup_d       = dup_q;
        first_d     = first_q;
        fwd_d       = fwd_q;
        abort_d     = abort_q;
        overflow_d  = overflow_q;
        pend_d      = pend_q;
        hsk_type_d  = hsk_type_q;
        s_tready_o  = 1'b0;
        m_tvalid_o  = 1'b0;
        m_tlast_o   = 1'b0;
        m_tdata_o   = '0;
        m_tuser_o   = 1'b0;
        hsk_valid_o = 1'b0;
        hsk_type_o  = '0;

        case (state_q)
            IDLE: begin
                if (tok_out_i) begin
                    first_d = 1'b1;
                    fwd_d   = 1'b0;
                    abort_d = 1'b0;
                    if (halt_i) begin
                        pend_d  = HSK_STALL;
                        state_d = RX_DISCARD;
                    end else if (free >= MAX_W) begin
                        state_d = RX_ACCEPT;
                    end else begin
                        pend_d  = HSK_NAK;
                        state_d = RX_DISCARD;
                    end
                end else if (tok_ping_i) begin
                    hsk_type_d = halt_i ? HSK_STALL : ((free >= MAX_W) ? HSK_ACK : HSK_NAK);
                    state_d    = HSK;
                end
            end

            RX_ACCEPT: begin
                if (pkt_abort_i || abort_q) begin
                    // Close a partially forwarded frame with a bad-flagged terminator beat.
                    if (fwd_q) begin
                        m_tvalid_o = 1'b1;
                        m_tlast_o  = 1'b1;
                        m_tuser_o  = 1'b1;
                        if (m_tready_i) state_d = IDLE;
                        else            abort_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    m_tvalid_o = s_tvalid_i;
                    s_tready_o = m_tready_i;
                    m_tdata_o  = s_tdata_i;
                    m_tlast_o  = s_tlast_i;
                    m_tuser_o  = s_tlast_i & (dup_now | crc_err_i);
                    if (s_tvalid_i && !m_tready_i) overflow_d = 1'b1;
                    if (s_tvalid_i && m_tready_i) begin
                        first_d = 1'b0;
                        fwd_d   = 1'b1;
                        dup_d   = dup_now;
                        if (s_tlast_i) begin
                            if (crc_err_i) begin
                                state_d = IDLE;
                            end else begin
                                state_d    = HSK;
                                hsk_type_d = accept_type;
                                if (!dup_now) toggle_d = ~toggle_q;
                            end
                        end
                    end
                end
            end

            RX_DISCARD: begin
                s_tready_o = 1'b1;
                if (pkt_abort_i) begin
                    state_d = IDLE;
                end else if (s_tvalid_i && s_tlast_i) begin
                    if (crc_err_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = HSK;
                        hsk_type_d = pend_q;
                    end
                end
            end

            HSK: begin
                hsk_valid_o = 1'b1;
                hsk_type_o  = hsk_type_q;
                if (hsk_ready_i) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (clear_halt_i) toggle_d = 1'b0;
    end

    assign toggle_o   = toggle_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bulk_out_flow_ctrl.sv
// Self-checking bench for bulk_out_flow_ctrl: scoreboard of forwarded beats
// and handshakes plus per-scenario checks of toggle, latency and flags.
module tb_bulk_out_flow_ctrl;
    import usb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tok_out_i = 1'b0, tok_ping_i = 1'b0, pid_toggle_i = 1'b0;
    logic        pkt_abort_i = 1'b0, halt_i = 1'b0, clear_halt_i = 1'b0;
    logic [11:0] level_i = '0;
    logic        s_tvalid_i = 1'b0, s_tlast_i = 1'b0, crc_err_i = 1'b0;
    logic [7:0]  s_tdata_i = '0;
    logic        s_tready_o;
    logic        m_tvalid_o, m_tlast_o, m_tuser_o;
    logic [7:0]  m_tdata_o;
    logic        m_tready_i = 1'b1;
    logic        hsk_valid_o, hsk_ready_i = 1'b1;
    logic [1:0]  hsk_type_o;
    logic        toggle_o, overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt = 0;
    logic exp_tog = 1'b0;

    logic [9:0] exp_beats[$];
    logic [1:0] exp_hsk[$];
    logic [9:0] obs_b, exp_b;
    logic [1:0] exp_h;

    always #5 clk = ~clk;

    bulk_out_flow_ctrl #(.MAX_PKT(512), .FIFO_DEPTH(2048), .LEVEL_BITS(12)) dut (
        .bulk_ep_out_clock(clk), .reset_n(reset_n),
        .tok_out_i(tok_out_i), .tok_ping_i(tok_ping_i), .pid_toggle_i(pid_toggle_i),
        .pkt_abort_i(pkt_abort_i), .halt_i(halt_i), .clear_halt_i(clear_halt_i),
        .level_i(level_i),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i),
        .s_tdata_i(s_tdata_i), .crc_err_i(crc_err_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
        .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
        .hsk_valid_o(hsk_valid_o), .hsk_type_o(hsk_type_o), .hsk_ready_i(hsk_ready_i),
        .toggle_o(toggle_o), .overflow_o(overflow_o)
    );

    // Scoreboard: pop and compare whenever the DUT completes a beat or handshake
    always @(negedge clk) begin
        if (reset_n) begin
            if (s_tvalid_i && !s_tready_o) stall_cnt++;
            if (m_tvalid_o && m_tready_i) begin
                obs_b = {m_tlast_o, m_tlast_o & m_tuser_o, m_tdata_o};
                n_cmp++;
                if (exp_beats.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got %h, required no beat", obs_b);
                end else begin
                    exp_b = exp_beats.pop_front();
                    if (obs_b !== exp_b) begin
                        n_err++;
                        $display("FAIL beat {last,user,data}: got %h, required %h", obs_b, exp_b);
                    end
                end
            end
            if (hsk_valid_o && hsk_ready_i) begin
                n_cmp++;
                if (exp_hsk.size() == 0) begin
                    n_err++;
                    $display("FAIL hsk_unexpected: got %0d, required none", hsk_type_o);
                end else begin
                    exp_h = exp_hsk.pop_front();
                    if (hsk_type_o !== exp_h) begin
                        n_err++;
                        $display("FAIL hsk_type: got %0d, required %0d", hsk_type_o, exp_h);
                    end
                end
            end
        end
    end

    // Stimulus only: drives one OUT transaction and pushes the expected beats
    task automatic send_pkt(input int n, input bit pid, input bit crc_bad,
                            input int abort_at, input int stall_at,
                            input bit fwd, input bit dup);
        logic [7:0] d;
        tok_out_i = 1'b1;
        @(posedge clk); #1;
        tok_out_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
                pkt_abort_i = 1'b1; m_tready_i = 1'b0;
                @(posedge clk); #1;
                pkt_abort_i = 1'b0;
                @(posedge clk); #1;
                m_tready_i = 1'b1;
                if (fwd && i > 0) exp_beats.push_back({1'b1, 1'b1, 8'h00});
                @(posedge clk); #1;
                return;
            end
            d = 8'($urandom_range(0, 255));
            s_tvalid_i   = 1'b1;
            s_tdata_i    = d;
            s_tlast_i    = (i == n - 1);
            pid_toggle_i = pid;
            crc_err_i    = crc_bad && (i == n - 1);
            if (fwd) exp_beats.push_back({s_tlast_i, s_tlast_i & (dup | crc_bad), d});
            if (i == stall_at) begin
                m_tready_i = 1'b0;
                @(posedge clk); #1;
                m_tready_i = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; crc_err_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid_o, s_tready_o, m_tlast_o, m_tuser_o, m_tdata_o, hsk_valid_o,
             hsk_type_o, toggle_o, overflow_o} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v%b r%b l%b u%b d%h h%b t%0d tog%b ovf%b, required all 0",
                     m_tvalid_o, s_tready_o, m_tlast_o, m_tuser_o, m_tdata_o, hsk_valid_o,
                     hsk_type_o, toggle_o, overflow_o);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_tog = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_accept;
        level_i = 12'd0;
        exp_hsk.push_back(HSK_ACK);
        send_pkt(64, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0);
        exp_tog = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hsk_valid_o !== 1'b1) begin
            n_err++; $display("FAIL accept_hsk_latency: got %b, required 1", hsk_valid_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL accept_toggle: got %b, required %b", toggle_o, exp_tog);
        end
    endtask

    task automatic test_nak;
        level_i = 12'd1600;
        stall_cnt = 0;
        exp_hsk.push_back(HSK_NAK);
        send_pkt(64, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (hsk_valid_o !== 1'b1) begin
            n_err++; $display("FAIL nak_hsk_latency: got %b, required 1", hsk_valid_o);
        end
        n_cmp++;
        if (stall_cnt !== 0) begin
            n_err++; $display("FAIL nak_s_tready: got %0d stalled cycles, required 0", stall_cnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL nak_toggle: got %b, required %b", toggle_o, exp_tog);
        end
    endtask

    task automatic test_dup_and_crc;
        level_i = 12'd0;
        exp_hsk.push_back(HSK_ACK);
        send_pkt(64, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL dup_toggle: got %b, required %b", toggle_o, exp_tog);
        end
        send_pkt(16, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (hsk_valid_o !== 1'b0) begin
                n_err++; $display("FAIL crc_no_hsk: got %b, required 0", hsk_valid_o);
            end
        end
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL crc_toggle: got %b, required %b", toggle_o, exp_tog);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort_zlp;
        level_i = 12'd0;
        send_pkt(20, 1'b1, 1'b0, 10, -1, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({hsk_valid_o, m_tvalid_o, toggle_o} !== {2'b00, exp_tog}) begin
            n_err++;
            $display("FAIL abort_idle {hsk,mvalid,tog}: got %b, required %b",
                     {hsk_valid_o, m_tvalid_o, toggle_o}, {2'b00, exp_tog});
        end
        @(posedge clk); #1;
        exp_hsk.push_back(HSK_ACK);
        send_pkt(1, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0);
        exp_tog = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL zlp_toggle: got %b, required %b", toggle_o, exp_tog);
        end
    endtask

    task automatic test_ping;
        logic [11:0] lv[2];
        logic [1:0]  ty[2];
        lv[0] = 12'd1600; ty[0] = HSK_NAK;
        lv[1] = 12'd0;    ty[1] = HSK_ACK;
        for (int k = 0; k < 2; k++) begin
            level_i = lv[k];
            exp_hsk.push_back(ty[k]);
            tok_ping_i = 1'b1;
            @(posedge clk); #1;
            tok_ping_i = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (hsk_valid_o !== 1'b1) begin
                n_err++; $display("FAIL ping_latency[%0d]: got %b, required 1", k, hsk_valid_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nyet;
        level_i = 12'd1100;
`ifdef BULK_OUT_NYET_EN
        exp_hsk.push_back(HSK_NYET);
`else
        exp_hsk.push_back(HSK_ACK);
`endif
        send_pkt(32, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0);
        exp_tog = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL nyet_toggle: got %b, required %b", toggle_o, exp_tog);
        end
    endtask

    task automatic test_overflow;
        level_i = 12'd0;
        exp_hsk.push_back(HSK_ACK);
        send_pkt(8, 1'b1, 1'b0, -1, 3, 1'b1, 1'b0);
        exp_tog = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({overflow_o, toggle_o} !== {1'b1, exp_tog}) begin
            n_err++;
            $display("FAIL overflow {ovf,tog}: got %b, required %b", {overflow_o, toggle_o}, {1'b1, exp_tog});
        end
    endtask

    task automatic test_halt;
        logic [1:0] t0;
        level_i = 12'd0;
        exp_hsk.push_back(HSK_ACK);
        send_pkt(4, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0);
        exp_tog = 1'b1;
        @(posedge clk); #1;
        halt_i = 1'b1;
        exp_hsk.push_back(HSK_STALL);
        send_pkt(16, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL halt_toggle: got %b, required %b", toggle_o, exp_tog);
        end
        hsk_ready_i = 1'b0;
        exp_hsk.push_back(HSK_STALL);
        tok_ping_i = 1'b1;
        @(posedge clk); #1;
        tok_ping_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            t0 = hsk_type_o;
            n_cmp++;
            if ({hsk_valid_o, t0} !== {1'b1, HSK_STALL}) begin
                n_err++;
                $display("FAIL halt_hsk_hold[%0d]: got v%b t%0d, required v1 t3", c, hsk_valid_o, t0);
            end
            if (c == 2) begin
                tok_out_i = 1'b1;
                @(posedge clk); #1;
                tok_out_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        hsk_ready_i = 1'b1;
        @(posedge clk); #1;
        halt_i = 1'b0;
        clear_halt_i = 1'b1;
        @(posedge clk); #1;
        clear_halt_i = 1'b0;
        exp_tog = 1'b0;
        n_cmp++;
        if (toggle_o !== exp_tog) begin
            n_err++; $display("FAIL clear_halt_toggle: got %b, required %b", toggle_o, exp_tog);
        end
        n_cmp++;
        if (exp_beats.size() + exp_hsk.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d beats %0d hsk pending, required 0",
                     exp_beats.size(), exp_hsk.size());
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_nak();
        test_dup_and_crc();
        test_abort_zlp();
        test_ping();
        test_nyet();
        test_overflow();
        test_halt();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
